// File: rtl/bit_compare.sv
`default_nettype none
// ============================================================================
//  Module      : bit_compare
//  Description : One-bit magnitude-compare slice. It is chained from the MSB
//                to the LSB. A decision from a more-significant slice,
//                arriving on a_skip/b_skip, is passed through unchanged.
//                Otherwise the slice decides from its own a/b bit pair.
//                The outputs are either combinational or registered with one
//                cycle of latency, chosen by REG_OUT.
//  Ports       : clk    - rising-edge clock (used only when REG_OUT=1)
//                rst    - synchronous active-high reset (REG_OUT=1 only)
//                a, b   - current bit of operand A / operand B
//                a_skip - cascade-in: a higher slice decided A > B
//                b_skip - cascade-in: a higher slice decided B > A
//                a_g    - cascade-out: A greater at this bit or above
//                b_g    - cascade-out: B greater at this bit or above
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_compare #(
  parameter bit REG_OUT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic a_skip,
  input  logic b_skip,
  output logic a_g,
  output logic b_g
);

  // Next decision pair. a_skip is tested first, so the illegal case where
  // both skip inputs are set still resolves to "A greater". The two outputs
  // therefore can never both be 1.
  logic a_g_d;
  logic b_g_d;

  always_comb begin
    a_g_d = 1'b0;
    b_g_d = 1'b0;
    if (a_skip) begin
      a_g_d = 1'b1;
    end else if (b_skip) begin
      b_g_d = 1'b1;
    end else begin
      a_g_d = a & ~b;
      b_g_d = b & ~a;
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      logic a_g_q;
      logic b_g_q;

      // Reset has priority over the data path. The first edge after reset
      // is released loads the next decision pair in the normal way.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_g_q <= 1'b0;
          b_g_q <= 1'b0;
        end else begin
          a_g_q <= a_g_d;
          b_g_q <= b_g_d;
        end
      end

      assign a_g = a_g_q;
      assign b_g = b_g_q;
    end else begin : g_comb
      // In the combinational variant clk and rst have no function. They are
      // folded into a sink signal so the ports stay in the interface.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;

      assign a_g = a_g_d;
      assign b_g = b_g_d;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bit_compare.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_compare
//  Description : Self-checking bench for bit_compare. It drives a
//                combinational slice and a registered slice from the same
//                inputs. It also builds an 8-slice combinational chain and
//                checks it against integer magnitude comparison.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_compare;

  logic clk;
  logic rst;
  logic a, b, a_skip, b_skip;
  logic c_a_g, c_b_g;   // REG_OUT=0 slice
  logic r_a_g, r_b_g;   // REG_OUT=1 slice

  logic [7:0] op_a, op_b;
  wire  [8:0] ch_a_g;
  wire  [8:0] ch_b_g;

  int total = 0;
  int bad   = 0;

  // The expected output of the registered slice. It is valid after the
  // first clock edge.
  logic [1:0] exp_reg;
  logic       exp_valid = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  bit_compare #(.REG_OUT(1'b0)) u_comb (
    .clk(clk), .rst(rst), .a(a), .b(b), .a_skip(a_skip), .b_skip(b_skip),
    .a_g(c_a_g), .b_g(c_b_g)
  );

  bit_compare #(.REG_OUT(1'b1)) u_reg (
    .clk(clk), .rst(rst), .a(a), .b(b), .a_skip(a_skip), .b_skip(b_skip),
    .a_g(r_a_g), .b_g(r_b_g)
  );

  // The chain runs from the MSB slice (7) to the LSB slice (0). The final
  // decision appears on index 0.
  assign ch_a_g[8] = 1'b0;
  assign ch_b_g[8] = 1'b0;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_chain
      bit_compare #(.REG_OUT(1'b0)) u_slice (
        .clk(clk), .rst(rst), .a(op_a[gi]), .b(op_b[gi]),
        .a_skip(ch_a_g[gi+1]), .b_skip(ch_b_g[gi+1]),
        .a_g(ch_a_g[gi]), .b_g(ch_b_g[gi])
      );
    end
  endgenerate

  // Behavioural model of one slice: an upstream decision wins (A first),
  // otherwise compare the two bits as numbers.
  function automatic logic [1:0] mdl(input logic ia, input logic ib,
                                     input logic ias, input logic ibs);
    int va, vb;
    if (ias) return 2'b10;
    if (ibs) return 2'b01;
    va = ia ? 1 : 0;
    vb = ib ? 1 : 0;
    if (va > vb) return 2'b10;
    if (vb > va) return 2'b01;
    return 2'b00;
  endfunction

  // Behavioural model of the whole chain: plain unsigned magnitude compare.
  function automatic logic [1:0] mdl_word(input logic [7:0] wa, input logic [7:0] wb);
    int va, vb;
    va = int'(wa);
    vb = int'(wb);
    if (va > vb) return 2'b10;
    if (vb > va) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_reg   <= rst ? 2'b00 : mdl(a, b, a_skip, b_skip);
    exp_valid <= 1'b1;
  end

  // Continuous compare on the falling edge. Inputs change only just after
  // a rising edge, so all outputs are settled at this point.
  always @(negedge clk) begin
    check("comb_model", {c_a_g, c_b_g}, mdl(a, b, a_skip, b_skip));
    check("comb_excl", {1'b0, c_a_g & c_b_g}, 2'b00);
    check("chain_model", {ch_a_g[0], ch_b_g[0]}, mdl_word(op_a, op_b));
    if (exp_valid) begin
      check("reg_model", {r_a_g, r_b_g}, exp_reg);
      check("reg_excl", {1'b0, r_a_g & r_b_g}, 2'b00);
    end
  end

  // Wait for a rising edge, then apply new inputs 2 time units after it.
  task automatic drive(input logic ia, input logic ib, input logic ias,
                       input logic ibs, input logic irst);
    @(posedge clk);
    #2;
    a = ia; b = ib; a_skip = ias; b_skip = ibs; rst = irst;
  endtask

  logic [7:0] tab_a [6];
  logic [7:0] tab_b [6];
  logic [1:0] tab_e [6];

  initial begin
    rst = 1'b1; a = 1'b0; b = 1'b0; a_skip = 1'b0; b_skip = 1'b0;
    op_a = 8'h00; op_b = 8'h00;

    // Registered slice: reset held for two edges.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2 check("reg_rst_hold", {r_a_g, r_b_g}, 2'b00);

    // The combinational slice ignores reset.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 check("comb_during_rst", {c_a_g, c_b_g}, 2'b10);

    // Release reset. The first edge after release loads 1,0.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 check("reg_before_edge", {r_a_g, r_b_g}, 2'b00);
    @(posedge clk); #2 check("reg_one_edge", {r_a_g, r_b_g}, 2'b10);

    // Reset asserted mid-operation clears the outputs at the next edge.
    rst = 1'b1;
    @(posedge clk); #2 check("reg_mid_rst", {r_a_g, r_b_g}, 2'b00);

    // Combinational slice, no skip, all a,b pairs.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1 check("ns_00", {c_a_g, c_b_g}, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #1 check("ns_10", {c_a_g, c_b_g}, 2'b10);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); #1 check("ns_01", {c_a_g, c_b_g}, 2'b01);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); #1 check("ns_11", {c_a_g, c_b_g}, 2'b00);
    // a_skip forces A greater.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); #1 check("as_00", {c_a_g, c_b_g}, 2'b10);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); #1 check("as_10", {c_a_g, c_b_g}, 2'b10);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); #1 check("as_01", {c_a_g, c_b_g}, 2'b10);
    // b_skip overrides the local bit.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); #1 check("bs_10", {c_a_g, c_b_g}, 2'b01);
    // Both skips set: a_skip has priority.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0); #1 check("both_01", {c_a_g, c_b_g}, 2'b10);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0); #1 check("both_11", {c_a_g, c_b_g}, 2'b10);

    // Every input combination, with reset pulses mixed in, for the
    // continuous model compare on both slices.
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      v = 5'(i);
      drive(v[0], v[1], v[2], v[3], (v[4] & v[0]));
    end

    // Chain vectors.
    tab_a[0] = 8'h5A; tab_b[0] = 8'h5B; tab_e[0] = 2'b01;
    tab_a[1] = 8'hC3; tab_b[1] = 8'hC3; tab_e[1] = 2'b00;
    tab_a[2] = 8'h80; tab_b[2] = 8'h7F; tab_e[2] = 2'b10;
    tab_a[3] = 8'h00; tab_b[3] = 8'hFF; tab_e[3] = 2'b01;
    tab_a[4] = 8'hFF; tab_b[4] = 8'hFE; tab_e[4] = 2'b10;
    tab_a[5] = 8'h00; tab_b[5] = 8'h00; tab_e[5] = 2'b00;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      op_a = tab_a[i]; op_b = tab_b[i];
      #1 check($sformatf("chain_%0d", i), {ch_a_g[0], ch_b_g[0]}, tab_e[i]);
    end

    // Pseudo-random chain operands, checked by the continuous compare.
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      op_a = 8'($urandom_range(0, 255));
      op_b = (i % 4 == 0) ? op_a : 8'($urandom_range(0, 255));
    end

    @(posedge clk); #6;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bit_compare.md
BIT_COMPARE -- requirements
Module: bit_compare

Interface
REQ-001 Parameter REG_OUT, default 0: 0 = outputs combinational from the current inputs; 1 = outputs registered with 1-cycle latency.
REQ-002 clk  input  1  single clock; the only clock in the block; rising-edge active.
REQ-003 rst  input  1  reset, synchronous and active-high; sampled on rising clk only.
REQ-004 a  input  1  current bit of operand A.
REQ-005 b  input  1  current bit of operand B.
REQ-006 a_skip  input  1  cascade-in: a more-significant slice has already decided A > B.
REQ-007 b_skip  input  1  cascade-in: a more-significant slice has already decided B > A.
REQ-008 a_g  output  1  cascade-out: A greater, decided at this bit or above.
REQ-009 b_g  output  1  cascade-out: B greater, decided at this bit or above.
REQ-010 Port order: clk, rst, a, b, a_skip, b_skip, a_g, b_g.

Function
REQ-011 The block SHALL compute the next decision pair (a_g_n, b_g_n) as follows.
REQ-012 If a_skip=1, a_g_n=1 and b_g_n=0, regardless of a and b.
REQ-013 Else if b_skip=1, a_g_n=0 and b_g_n=1, regardless of a and b.
REQ-014 Else a_g_n = a AND NOT b, and b_g_n = b AND NOT a.
REQ-015 With no skip and a=b, both outputs SHALL be 0, meaning equal so far.
REQ-016 If a_skip=1 and b_skip=1 together, a_skip SHALL take priority: a_g=1, b_g=0. This input is illegal in a well-formed chain but the output is still deterministic.
REQ-017 a_g and b_g SHALL never both be 1.
REQ-018 REG_OUT=0: a_g/b_g = a_g_n/b_g_n with zero-cycle latency. Outputs SHALL be valid within the same time step as an input change. clk and rst do not affect the outputs.
REQ-019 REG_OUT=1: on each rising clk with rst=0, a_g/b_g SHALL load a_g_n/b_g_n, giving exactly 1-cycle latency and holding between edges.
REQ-020 Slices SHALL be chainable MSB to LSB: a_g/b_g of slice i drive a_skip/b_skip of slice i-1. The LSB slice output then gives A>B (a_g), B>A (b_g), or A==B (both 0).
REQ-021 No X SHALL propagate to the outputs when all inputs are known. There SHALL be no latches.

Reset
REQ-022 REG_OUT=1: rst=1 at a rising clk SHALL set a_g=0 and b_g=0, taking priority over the data path. rst asserted mid-operation SHALL clear the outputs at the next edge.
REQ-023 REG_OUT=1: the first edge after rst deasserts SHALL load a_g_n/b_g_n normally.
REQ-024 REG_OUT=0: rst SHALL have no effect. The outputs SHALL track the inputs at all times, including while rst=1.

Verification
REQ-025 REG_OUT=0, skips=0, exhaustive a,b: 00->a_g=0,b_g=0; 10->1,0; 01->0,1; 11->0,0.
REQ-026 REG_OUT=0, a_skip=1, b_skip=0, a,b in {00,10,01}: every case -> a_g=1, b_g=0.
REQ-027 REG_OUT=0, a_skip=0, b_skip=1, a=1, b=0: -> a_g=0, b_g=1 (skip overrides the local bit).
REQ-028 REG_OUT=0, a_skip=1, b_skip=1, any a,b: -> a_g=1, b_g=0.
REQ-029 REG_OUT=1: hold rst=1 for 2 edges -> outputs 0,0. Then apply a=1, b=0, skips=0 -> a_g=1 after exactly 1 edge. Then assert rst with inputs unchanged -> 0,0 at the next edge.
REQ-030 Chain 8 REG_OUT=0 slices with A=0x5A and B=0x5B -> final b_g=1, a_g=0. With A=B=0xC3 -> final outputs 0,0.
